// File: rtl/iecdrv_head_tracker.sv
// rtl/iecdrv_head_tracker.sv - stepper head position, disk-change sense and track-save request controller
module iecdrv_head_tracker #(
    parameter int MAX_HTRACK   = 84,
    parameter int START_HTRACK = 36,
    parameter int SIDES        = 1,
    parameter int CHG_W        = 24,
    parameter int WP_BIT       = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       img_mounted,
    input  logic       img_readonly,
    input  logic       img_nonempty,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       act,
    input  logic       side_i,
    input  logic       we,
    output logic [6:0] htrack,
    output logic       side_o,
    output logic       tr00_sense_n,
    output logic       wps_n,
    output logic       disk_present,
    output logic       save_req,
    output logic [6:0] save_htrack,
    output logic       save_side,
    input  logic       save_ack,
    output logic       save_ovf
);

    logic [1:0]       r_stp_old;
    logic [1:0]       r_delta;
    logic [6:0]       r_htrack;
    logic             r_side;
    logic             r_dirty;
    logic             r_mnt_d;
    logic             r_readonly;
    logic             r_present;
    logic [CHG_W-1:0] r_chg_cnt;
    logic             r_save_req;
    logic [6:0]       r_save_htrack;
    logic             r_save_side;
    logic             r_pend;
    logic [6:0]       r_pend_htrack;
    logic             r_pend_side;
    logic             r_ovf;

    logic w_mount;
    logic w_step_up;
    logic w_step_dn;
    logic w_side_chg;
    logic w_flush;
    logic w_ack;

    assign w_mount    = img_mounted & ~r_mnt_d;
    assign w_step_up  = mtr && (r_delta == 2'b01) && (r_htrack < 7'(MAX_HTRACK));
    assign w_step_dn  = mtr && (r_delta == 2'b11) && (r_htrack != 7'd0);
    assign w_side_chg = (SIDES == 2) && (side_i != r_side);
    // A mount drops the dirty track without saving it, so it masks every trigger.
    assign w_flush    = r_dirty && !w_mount && (w_step_up || w_step_dn || w_side_chg || !act);
    assign w_ack      = save_ack && r_save_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stp_old <= stp;
            r_delta   <= 2'b00;
            r_htrack  <= 7'(START_HTRACK);
            r_side    <= 1'b0;
        end else begin
            r_stp_old <= stp;
            r_delta   <= stp - r_stp_old;
            if (w_step_up)
                r_htrack <= r_htrack + 7'd1;
            else if (w_step_dn)
                r_htrack <= r_htrack - 7'd1;
            if (SIDES == 2)
                r_side <= side_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_dirty <= 1'b0;
        else if (w_mount)
            r_dirty <= 1'b0;
        else if (we)
            r_dirty <= 1'b1;
        else if (w_flush)
            r_dirty <= 1'b0;
    end

    // Image state belongs to the host side and deliberately survives a drive reset.
    always_ff @(posedge clk) begin
        r_mnt_d <= img_mounted;
        if (w_mount) begin
            r_chg_cnt  <= '1;
            r_readonly <= img_readonly;
            r_present  <= img_nonempty;
        end else if (ce && (r_chg_cnt != '0)) begin
            r_chg_cnt <= r_chg_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_save_req    <= 1'b0;
            r_save_htrack <= 7'd0;
            r_save_side   <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_htrack <= 7'd0;
            r_pend_side   <= 1'b0;
            r_ovf         <= 1'b0;
        end else if (r_save_req) begin
            if (w_ack)
                r_save_req <= 1'b0;
            if (w_flush) begin
                if (r_pend)
                    r_ovf <= 1'b1;
                r_pend        <= 1'b1;
                r_pend_htrack <= r_htrack;
                r_pend_side   <= r_side;
            end
        end else if (r_pend) begin
            // Pending goes out first so saves leave in the order they were captured.
            r_save_req    <= 1'b1;
            r_save_htrack <= r_pend_htrack;
            r_save_side   <= r_pend_side;
            r_pend        <= w_flush;
            if (w_flush) begin
                r_pend_htrack <= r_htrack;
                r_pend_side   <= r_side;
            end
        end else if (w_flush) begin
            r_save_req    <= 1'b1;
            r_save_htrack <= r_htrack;
            r_save_side   <= r_side;
        end
    end

    assign htrack       = r_htrack;
    assign side_o       = r_side;
    assign tr00_sense_n = |r_htrack;
    assign wps_n        = ~r_readonly ^ r_chg_cnt[WP_BIT];
    assign disk_present = r_present;
    assign save_req     = r_save_req;
    assign save_htrack  = r_save_htrack;
    assign save_side    = r_save_side;
    assign save_ovf     = r_ovf;

endmodule

// File: tb/tb_iecdrv_head_tracker.sv
// tb/tb_iecdrv_head_tracker.sv - directed scoreboard bench for iecdrv_head_tracker
module tb_iecdrv_head_tracker;

    logic       clk = 1'b0;
    logic       reset, ce, img_mounted, img_readonly, img_nonempty;
    logic [1:0] stp;
    logic       mtr, act, side_i, we, save_ack;
    logic [6:0] htrack, save_htrack;
    logic       side_o, tr00_sense_n, wps_n, disk_present, save_req, save_side, save_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] cnt_model;
    logic [7:0] exp_save;

    always #5 clk = ~clk;

    iecdrv_head_tracker #(
        .MAX_HTRACK(84), .START_HTRACK(36), .SIDES(2), .CHG_W(8), .WP_BIT(6)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .img_mounted(img_mounted),
        .img_readonly(img_readonly), .img_nonempty(img_nonempty), .stp(stp),
        .mtr(mtr), .act(act), .side_i(side_i), .we(we), .htrack(htrack),
        .side_o(side_o), .tr00_sense_n(tr00_sense_n), .wps_n(wps_n),
        .disk_present(disk_present), .save_req(save_req), .save_htrack(save_htrack),
        .save_side(save_side), .save_ack(save_ack), .save_ovf(save_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] dir);
        stp = stp + dir;
        tick();
        tick();
    endtask

    task automatic we_pulse();
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic ack();
        save_ack = 1'b1;
        tick();
        save_ack = 1'b0;
    endtask

    task automatic wait_save(input string tag);
        int n;
        n = 0;
        while (!save_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'd0, save_req}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_save = sb_q.pop_front();
            chk({tag, "_htrack"}, {25'd0, save_htrack}, {25'd0, exp_save[6:0]});
            chk({tag, "_side"}, {31'd0, save_side}, {31'd0, exp_save[7]});
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0; img_nonempty = 1'b0;
        stp = 2'd0; mtr = 1'b0; act = 1'b1; side_i = 1'b0; we = 1'b0; save_ack = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_htrack", {25'd0, htrack}, 32'd36);
        chk("rst_tr00", {31'd0, tr00_sense_n}, 32'd1);
        chk("rst_req", {31'd0, save_req}, 32'd0);
        chk("rst_ovf", {31'd0, save_ovf}, 32'd0);
        chk("rst_side", {31'd0, side_o}, 32'd0);

        img_mounted = 1'b1; img_nonempty = 1'b1;
        tick();
        chk("mnt_present", {31'd0, disk_present}, 32'd1);
        chk("mnt_wps", {31'd0, wps_n}, 32'd0);

        mtr = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            stp = 2'(s);
            tick();
            chk("lat_1clk", {25'd0, htrack}, 32'(36 + s - 1));
            tick();
            chk("lat_2clk", {25'd0, htrack}, 32'(36 + s));
        end
        for (int i = 0; i < 45; i++) step(2'd1);
        chk("top_84", {25'd0, htrack}, 32'd84);
        step(2'd1);
        chk("top_clamp", {25'd0, htrack}, 32'd84);
        chk("top_nosave", {31'd0, save_req}, 32'd0);
        step(2'd2);
        chk("dbl_jump", {25'd0, htrack}, 32'd84);
        for (int i = 0; i < 84; i++) step(2'd3);
        chk("bot_0", {25'd0, htrack}, 32'd0);
        chk("bot_tr00", {31'd0, tr00_sense_n}, 32'd0);
        step(2'd3);
        chk("bot_clamp", {25'd0, htrack}, 32'd0);
        mtr = 1'b0;
        step(2'd1);
        chk("mtr_off", {25'd0, htrack}, 32'd0);
        mtr = 1'b1;
        for (int i = 0; i < 40; i++) step(2'd1);
        chk("at_40", {25'd0, htrack}, 32'd40);

        we_pulse();
        sb_q.push_back({1'b0, 7'd40});
        step(2'd1);
        chk("step_flush_ht", {25'd0, htrack}, 32'd41);
        wait_save("step_save");
        ack();
        chk("ack_drop", {31'd0, save_req}, 32'd0);

        we_pulse();
        act = 1'b0;
        sb_q.push_back({1'b0, 7'd41});
        tick();
        wait_save("act_save");
        step(2'd1);
        we_pulse();
        tick();
        sb_q.push_back({1'b0, 7'd42});
        chk("busy_hold_req", {31'd0, save_req}, 32'd1);
        chk("busy_hold_ht", {25'd0, save_htrack}, 32'd41);
        ack();
        chk("pend_gap", {31'd0, save_req}, 32'd0);
        tick();
        chk("pend_reassert", {31'd0, save_req}, 32'd1);
        wait_save("pend_save");
        chk("no_ovf", {31'd0, save_ovf}, 32'd0);
        ack();
        tick();

        we_pulse(); tick();
        sb_q.push_back({1'b0, 7'd42});
        wait_save("ovf_first");
        step(2'd1);
        we_pulse(); tick();
        step(2'd1);
        we_pulse(); tick();
        sb_q.push_back({1'b0, 7'd44});
        chk("ovf_set", {31'd0, save_ovf}, 32'd1);
        ack();
        tick();
        wait_save("ovf_last");
        ack();
        tick(); tick();
        chk("ovf_drained", {31'd0, save_req}, 32'd0);

        act = 1'b1;
        we_pulse();
        img_mounted = 1'b0; img_nonempty = 1'b0;
        tick();
        img_mounted = 1'b1;
        tick();
        cnt_model = 8'hFF;
        act = 1'b0;
        tick(); tick(); tick();
        chk("mnt_drop_dirty", {31'd0, save_req}, 32'd0);
        chk("mnt_present0", {31'd0, disk_present}, 32'd0);
        ce = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (cnt_model != 8'd0) cnt_model = cnt_model - 8'd1;
            chk("wps_cd", {31'd0, wps_n}, {31'd0, ~cnt_model[6]});
        end
        chk("wps_settled", {31'd0, wps_n}, 32'd1);
        ce = 1'b0;
        act = 1'b1;

        we_pulse();
        side_i = 1'b1;
        sb_q.push_back({1'b0, 7'd44});
        tick();
        chk("side_o", {31'd0, side_o}, 32'd1);
        wait_save("side_save");
        ack();
        tick();

        we_pulse();
        stp = stp + 2'd1;
        tick();
        act = 1'b0;
        sb_q.push_back({1'b1, 7'd44});
        tick();
        chk("coinc_ht", {25'd0, htrack}, 32'd45);
        wait_save("coinc_save");
        ack();
        tick(); tick();
        chk("coinc_single", {31'd0, save_req}, 32'd0);

        we_pulse(); tick();
        chk("mid_req", {31'd0, save_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_req", {31'd0, save_req}, 32'd0);
        chk("mid_rst_ht", {25'd0, htrack}, 32'd36);
        chk("mid_rst_side", {31'd0, side_o}, 32'd0);
        chk("mid_rst_present", {31'd0, disk_present}, 32'd0);
        chk("mid_rst_wps", {31'd0, wps_n}, 32'd1);
        ack();
        tick();
        chk("late_ack", {31'd0, save_req}, 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iecdrv_head_tracker.md
Name: iecdrv_head_tracker

Overview:
Parametrised head-position and track-dirty controller for the IEC drive family (1541/1571 class). It decodes stepper phases into a half-track position, and optionally a side, and derives the TR00 sense and write-protect/disk-change signals from image-mount events. It issues track-save requests to the SD track loader through a req/ack handshake with a one-deep pending slot. It replaces the ad-hoc track/save-toggle logic in drive tops and adds double-sided support.

Parameters:
MAX_HTRACK, 84, highest legal half-track index; the position never exceeds it.
START_HTRACK, 36, half-track loaded on reset.
SIDES, 1, 1 or 2; when 1, side_i is ignored and side_o is tied to 0.
CHG_W, 24, width of the disk-change timeout counter.
WP_BIT, 22, counter bit XORed into wps_n during a disk change.

Ports:
clk  in  1  drive clock
reset  in  1  synchronous, active-high
ce  in  1  drive clock enable; gates only the change-timeout countdown
img_mounted  in  1  mount strobe (level); its rising edge is a mount event
img_readonly  in  1  image read-only flag, sampled on the mount event
img_nonempty  in  1  image size non-zero, sampled on the mount event
stp  in  2  stepper phase from the drive VIA
mtr  in  1  spindle motor on
act  in  1  drive activity LED
side_i  in  1  head select (1571)
we  in  1  one-clock GCR write pulse
htrack  out  7  current half-track
side_o  out  1  current side
tr00_sense_n  out  1  low when htrack == 0
wps_n  out  1  write-protect sense, active low
disk_present  out  1  image mounted and non-empty
save_req  out  1  save request, held until acked
save_htrack  out  7  half-track to save, stable while save_req is high
save_side  out  1  side to save, stable while save_req is high
save_ack  in  1  one-clock acknowledge from the loader
save_ovf  out  1  sticky: a pending save was overwritten

Behaviour:
- Reset values: htrack = START_HTRACK, side_o = 0, dirty = 0, save_req = 0, pending = 0, save_ovf = 0, stp_old = stp.
- Mount state is not cleared by reset: readonly, disk_present and chg_cnt survive it.
- Reset mid-handshake: save_req drops and pending is discarded. A save_ack arriving afterwards is ignored.
- Mount event (img_mounted rising, detected through a registered copy):
  - chg_cnt = all ones; readonly = img_readonly; disk_present = img_nonempty.
  - dirty = 0 with no save; an in-flight save_req is left untouched.
- chg_cnt decrements by 1 on each ce while it is non-zero and saturates at 0.
- wps_n = ~readonly ^ chg_cnt[WP_BIT].
- Stepping:
  - Each clk registers stp_old <= stp and delta <= stp - stp_old (mod 4).
  - On the next clk, if mtr is high: delta 01 steps up when htrack < MAX_HTRACK; delta 11 steps down when htrack > 0.
  - delta 10 (double phase jump) and 00 are ignored.
  - A step at either limit does not move the head and is not a head change.
  - Latency: a stp change reaches htrack 2 clocks later.
  - Steps arriving while mtr = 0 are lost.
- Side (SIDES == 2): side_o <= side_i every clk. A side_o change is a head change.
- Dirty tracking:
  - we sets dirty.
  - A flush trigger captures (htrack, side_o) as they were before the head change, then clears dirty.
  - A we in the same cycle as a trigger leaves dirty = 1, attributed to the new position.
- Flush triggers, all requiring dirty = 1:
  - an accepted step;
  - a side change;
  - act = 0.
- Coincident triggers in one cycle produce exactly one flush.
- Save handshake:
  - If save_req = 0, the flush drives save_req = 1 with the captured values on the next clk.
  - If save_req = 1, the captured values go to the pending slot. If pending is already full, they overwrite it and save_ovf is set.
- save_ack while save_req = 1: save_req = 0 on the next clk.
  - If pending is full, save_req reasserts one clk later with the pending values, and pending clears.
  - A flush arriving in the same cycle as the ack goes to pending.
- save_ack while save_req = 0 is ignored.
- tr00_sense_n = |htrack (combinational from the register).

Test Plan:
- Reset → htrack = 36, tr00_sense_n = 1, save_req = 0. Drive mtr = 1 and stp sequence 0,1,2,3 → htrack = 39, with htrack first changing 2 clocks after each stp change.
- From htrack = 84: stp +1 → htrack stays 84, no save. Walk down to 0: tr00_sense_n = 0, and a further −1 keeps htrack = 0.
- we pulse at htrack = 40, then step up → save_req = 1, save_htrack = 40, htrack = 41. Ack → save_req = 0 the next clk.
- we, then act 1→0 while save_req is busy → pending holds. Ack → save_req drops for 1 clk, then reasserts with the pending track. Repeat twice without ack → save_ovf = 1.
- Mount with img_readonly = 0 → wps_n toggles as chg_cnt[22] changes during countdown under ce, then settles at 1 once chg_cnt reaches 0 (after 2^24−1 ce pulses). disk_present follows img_nonempty. A prior dirty flag is dropped without a save.
- SIDES = 2: we on side 0, then side_i = 1 → save_side = 0, side_o = 1. A simultaneous step and act-fall → exactly one save_req.
